// File: rtl/alu_op_sequencer_pkg.sv
// alu_pkg: opcodes, default widths, FSM state type and response record shared by
// the ALU operation sequencer, its interface and its bench.
package alu_pkg;

   localparam int DEF_DATA_W = 16;
   localparam int DEF_TAG_W  = 4;
   localparam int SHAMT_W    = 5;

   localparam logic [3:0] OPC_ADD  = 4'd0;
   localparam logic [3:0] OPC_SUB  = 4'd1;
   localparam logic [3:0] OPC_AND  = 4'd2;
   localparam logic [3:0] OPC_OR   = 4'd3;
   localparam logic [3:0] OPC_SLL  = 4'd4;
   localparam logic [3:0] OPC_MAX  = 4'd5;
   localparam logic [3:0] OPC_DIV  = 4'd6;
   localparam logic [3:0] OPC_SLTU = 4'd7;
   localparam logic [3:0] OPC_SRL  = 4'd8;
   localparam logic [3:0] OPC_NAND = 4'd9;
   localparam logic [3:0] OPC_LAST = 4'd9;

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      RESP
   } state_t;

   typedef struct packed {
      logic [DEF_DATA_W-1:0] result;
      logic                  carry;
      logic [DEF_TAG_W-1:0]  tag;
      logic                  err;
   } rsp_t;

   function automatic logic opcodeLegal(input logic [3:0] op);
      return op <= OPC_LAST;
   endfunction

   // Only the arithmetic ops produce a meaningful carry; everything else reports 0.
   function automatic logic carryKept(input logic [3:0] op);
      return (op == OPC_ADD) || (op == OPC_SUB);
   endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// alu_op_sequencer_if: request, response and ALU-side signals of the sequencer.
// slave = the sequencer itself, master = command source plus ALU.
interface alu_op_sequencer_if
   import alu_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int TAG_W  = DEF_TAG_W
);

   logic               req_valid;
   logic               req_ready;
   logic [3:0]         req_opcode;
   logic [DATA_W-1:0]  req_a;
   logic [DATA_W-1:0]  req_b;
   logic [SHAMT_W-1:0] req_shamt;
   logic [TAG_W-1:0]   req_tag;

   logic [3:0]         alu_opcode;
   logic [DATA_W-1:0]  alu_input1;
   logic [DATA_W-1:0]  alu_input2;
   logic [SHAMT_W-1:0] alu_shift_value;
   logic [DATA_W-1:0]  alu_result;
   logic               alu_carry;

   logic               rsp_valid;
   logic               rsp_ready;
   logic [DATA_W-1:0]  rsp_result;
   logic               rsp_carry;
   logic [TAG_W-1:0]   rsp_tag;
   logic               rsp_err;

   logic               busy;

   modport slave (
      input  req_valid, req_opcode, req_a, req_b, req_shamt, req_tag,
      input  alu_result, alu_carry, rsp_ready,
      output req_ready, alu_opcode, alu_input1, alu_input2, alu_shift_value,
      output rsp_valid, rsp_result, rsp_carry, rsp_tag, rsp_err, busy
   );

   modport master (
      output req_valid, req_opcode, req_a, req_b, req_shamt, req_tag,
      output alu_result, alu_carry, rsp_ready,
      input  req_ready, alu_opcode, alu_input1, alu_input2, alu_shift_value,
      input  rsp_valid, rsp_result, rsp_carry, rsp_tag, rsp_err, busy
   );

endinterface

// File: rtl/alu_op_sequencer_req_fifo.sv
// alu_req_fifo: synchronous FIFO holding queued ALU requests. Pointers carry one
// extra wrap bit so full and empty are distinguished by the MSB comparison.
module alu_req_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_pushData,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_popData,
   output logic             o_full,
   output logic             o_empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wrPtr;
   logic [AW:0]      r_rdPtr;
   logic             w_doPush;
   logic             w_doPop;

   assign o_empty   = (r_wrPtr == r_rdPtr);
   assign o_full    = (r_wrPtr[AW] != r_rdPtr[AW]) && (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
   assign w_doPush  = i_push && !o_full;
   assign w_doPop   = i_pop && !o_empty;
   assign o_popData = r_mem[r_rdPtr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
      end else begin
         if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
         if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
      end
   end

   // Storage needs no reset: an entry is only read after it has been written.
   always_ff @(posedge clk) begin
      if (w_doPush) r_mem[r_wrPtr[AW-1:0]] <= i_pushData;
   end

endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: queues ALU requests, drives them into the ALU one at a time and
// returns tagged results. Define ALU_SEQ_DIV0_ERR_EN to reject DIV by zero unissued.
module alu_op_sequencer
   import alu_pkg::*;
#(
   parameter int DATA_W        = DEF_DATA_W,
   parameter int FIFO_DEPTH    = 4,
   parameter int TAG_W         = DEF_TAG_W,
   parameter int SETTLE_CYCLES = 1
) (
   input logic               clk,
   input logic               rst,
   alu_op_sequencer_if.slave bus
);

   localparam int ENTRY_W = 4 + 2 * DATA_W + SHAMT_W + TAG_W;
   localparam int CNT_W   = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;

   logic [ENTRY_W-1:0] w_pushData;
   logic [ENTRY_W-1:0] w_headData;
   logic               w_fifoFull;
   logic               w_fifoEmpty;
   logic               w_push;
   logic               w_pop;
   logic               w_issue;
   logic               w_headReject;

   logic [3:0]         w_headOpcode;
   logic [DATA_W-1:0]  w_headA;
   logic [DATA_W-1:0]  w_headB;
   logic [SHAMT_W-1:0] w_headShamt;
   logic [TAG_W-1:0]   w_headTag;

   state_t             r_state,        w_stateNext;
   logic [CNT_W-1:0]   r_cnt,          w_cntNext;
   logic [TAG_W-1:0]   r_pendTag,      w_pendTagNext;
   logic [3:0]         r_aluOpcode,    w_aluOpcodeNext;
   logic [DATA_W-1:0]  r_aluInput1,    w_aluInput1Next;
   logic [DATA_W-1:0]  r_aluInput2,    w_aluInput2Next;
   logic [SHAMT_W-1:0] r_aluShift,     w_aluShiftNext;
   logic [DATA_W-1:0]  r_rspResult,    w_rspResultNext;
   logic               r_rspCarry,     w_rspCarryNext;
   logic [TAG_W-1:0]   r_rspTag,       w_rspTagNext;
   logic               r_rspErr,       w_rspErrNext;

   assign w_push     = bus.req_valid && !w_fifoFull;
   assign w_pushData = {bus.req_opcode, bus.req_a, bus.req_b, bus.req_shamt, bus.req_tag};
   assign {w_headOpcode, w_headA, w_headB, w_headShamt, w_headTag} = w_headData;

   alu_req_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_reqFifo (
      .clk        (clk),
      .rst        (rst),
      .i_push     (w_push),
      .i_pushData (w_pushData),
      .i_pop      (w_pop),
      .o_popData  (w_headData),
      .o_full     (w_fifoFull),
      .o_empty    (w_fifoEmpty)
   );

`ifdef ALU_SEQ_DIV0_ERR_EN
   assign w_headReject = !opcodeLegal(w_headOpcode) ||
                         ((w_headOpcode == OPC_DIV) && (w_headB == '0));
`else
   assign w_headReject = !opcodeLegal(w_headOpcode);
`endif

   // Next-state logic; the head-of-queue decode is shared by IDLE and a RESP handshake
   // so back-to-back operations lose no cycle.
   always_comb begin
      w_stateNext     = r_state;
      w_cntNext       = r_cnt;
      w_pendTagNext   = r_pendTag;
      w_aluOpcodeNext = r_aluOpcode;
      w_aluInput1Next = r_aluInput1;
      w_aluInput2Next = r_aluInput2;
      w_aluShiftNext  = r_aluShift;
      w_rspResultNext = r_rspResult;
      w_rspCarryNext  = r_rspCarry;
      w_rspTagNext    = r_rspTag;
      w_rspErrNext    = r_rspErr;
      w_issue         = 1'b0;
      w_pop           = 1'b0;

      case (r_state)
         IDLE: begin
            w_issue = !w_fifoEmpty;
         end
         SETTLE: begin
            if (r_cnt == CNT_W'(1)) begin
               w_rspResultNext = bus.alu_result;
               w_rspCarryNext  = carryKept(r_aluOpcode) ? bus.alu_carry : 1'b0;
               w_rspTagNext    = r_pendTag;
               w_rspErrNext    = 1'b0;
               w_stateNext     = RESP;
            end else begin
               w_cntNext = r_cnt - 1'b1;
            end
         end
         RESP: begin
            if (bus.rsp_ready) begin
               if (!w_fifoEmpty) w_issue = 1'b1;
               else              w_stateNext = IDLE;
            end
         end
         default: w_stateNext = IDLE;
      endcase

      if (w_issue) begin
         w_pop = 1'b1;
         if (w_headReject) begin
            w_rspResultNext = '0;
            w_rspCarryNext  = 1'b0;
            w_rspTagNext    = w_headTag;
            w_rspErrNext    = 1'b1;
            w_stateNext     = RESP;
         end else begin
            w_aluOpcodeNext = w_headOpcode;
            w_aluInput1Next = w_headA;
            w_aluInput2Next = w_headB;
            w_aluShiftNext  = w_headShamt;
            w_pendTagNext   = w_headTag;
            w_cntNext       = CNT_W'(SETTLE_CYCLES);
            w_stateNext     = SETTLE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_pendTag   <= '0;
         r_aluOpcode <= '0;
         r_aluInput1 <= '0;
         r_aluInput2 <= '0;
         r_aluShift  <= '0;
         r_rspResult <= '0;
         r_rspCarry  <= 1'b0;
         r_rspTag    <= '0;
         r_rspErr    <= 1'b0;
      end else begin
         r_state     <= w_stateNext;
         r_cnt       <= w_cntNext;
         r_pendTag   <= w_pendTagNext;
         r_aluOpcode <= w_aluOpcodeNext;
         r_aluInput1 <= w_aluInput1Next;
         r_aluInput2 <= w_aluInput2Next;
         r_aluShift  <= w_aluShiftNext;
         r_rspResult <= w_rspResultNext;
         r_rspCarry  <= w_rspCarryNext;
         r_rspTag    <= w_rspTagNext;
         r_rspErr    <= w_rspErrNext;
      end
   end

   assign bus.req_ready       = !w_fifoFull;
   assign bus.busy            = (r_state != IDLE) || !w_fifoEmpty;
   assign bus.rsp_valid       = (r_state == RESP);
   assign bus.rsp_result      = r_rspResult;
   assign bus.rsp_carry       = r_rspCarry;
   assign bus.rsp_tag         = r_rspTag;
   assign bus.rsp_err         = r_rspErr;
   assign bus.alu_opcode      = r_aluOpcode;
   assign bus.alu_input1      = r_aluInput1;
   assign bus.alu_input2      = r_aluInput2;
   assign bus.alu_shift_value = r_aluShift;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed and random checks of alu_op_sequencer against a
// queue-based response model; the bench also plays the combinational ALU.
module tb_alu_op_sequencer;
   import alu_pkg::*;

   logic clk;
   logic rst;
   int   assertCount = 0;
   int   failCount   = 0;
   int   cycle       = 0;
   bit   lastPush    = 0;
   bit   prevHeld    = 0;
   logic [31:0] prevFields = '0;
   rsp_t expQ[$];
   int   rspCycles[$];

   alu_op_sequencer_if #(.DATA_W(16), .TAG_W(4)) bus ();

   alu_op_sequencer #(
      .DATA_W        (16),
      .FIFO_DEPTH    (4),
      .TAG_W         (4),
      .SETTLE_CYCLES (1)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stand-in ALU: carry out of ADD, borrow of SUB, parity junk on every other op.
   function automatic logic [16:0] aluCompute(input logic [3:0] op, input logic [15:0] a,
                                              input logic [15:0] b, input logic [4:0] sh);
      logic [16:0] r;
      case (op)
         OPC_ADD:  r = {1'b0, a} + {1'b0, b};
         OPC_SUB:  r = {(a < b), a - b};
         OPC_AND:  r = {1'b0, a & b};
         OPC_OR:   r = {1'b0, a | b};
         OPC_SLL:  r = {1'b0, a << sh};
         OPC_MAX:  r = {1'b0, (a > b) ? a : b};
         OPC_DIV:  r = {1'b0, (b == 16'h0) ? 16'h0 : a / b};
         OPC_SLTU: r = {16'h0, (a < b)};
         OPC_SRL:  r = {1'b0, a >> sh};
         OPC_NAND: r = {1'b0, ~(a & b)};
         default:  r = 17'h0;
      endcase
      if (op != OPC_ADD && op != OPC_SUB) r[16] = ^r[15:0];
      return r;
   endfunction

   always_comb begin
      {bus.alu_carry, bus.alu_result} = aluCompute(bus.alu_opcode, bus.alu_input1,
                                                   bus.alu_input2, bus.alu_shift_value);
   end

   function automatic rsp_t expectRsp(input logic [3:0] op, input logic [15:0] a,
                                      input logic [15:0] b, input logic [4:0] sh,
                                      input logic [3:0] tag);
      rsp_t        e;
      logic [16:0] r;
      logic        rejected;
      rejected = (op > OPC_LAST);
`ifdef ALU_SEQ_DIV0_ERR_EN
      if (op == OPC_DIV && b == 16'h0) rejected = 1'b1;
`endif
      e.tag    = tag;
      e.err    = rejected;
      e.result = 16'h0;
      e.carry  = 1'b0;
      if (!rejected) begin
         r        = aluCompute(op, a, b, sh);
         e.result = r[15:0];
         e.carry  = (op == OPC_ADD || op == OPC_SUB) ? r[16] : 1'b0;
      end
      return e;
   endfunction

   function automatic logic [31:0] packRsp(input logic err, input logic [3:0] tag,
                                           input logic carry, input logic [15:0] result);
      return {10'h0, err, tag, carry, result};
   endfunction

   function automatic logic [31:0] rspFields();
      return packRsp(bus.rsp_err, bus.rsp_tag, bus.rsp_carry, bus.rsp_result);
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // One clock: settle handshakes against the model, then advance to #1 after the edge.
   task automatic stepCycle();
      bit   pushNow;
      bit   popNow;
      rsp_t e;
      pushNow = !rst && bus.req_valid && bus.req_ready;
      popNow  = !rst && bus.rsp_valid && bus.rsp_ready;
      if (!rst && prevHeld) begin
         checkOutput("rspHeldValid", {31'h0, bus.rsp_valid}, 32'h1);
         checkOutput("rspHeldFields", rspFields(), prevFields);
      end
      prevHeld   = !rst && bus.rsp_valid && !bus.rsp_ready;
      prevFields = rspFields();
      if (popNow) begin
         checkOutput("rspExpected", {31'h0, expQ.size() > 0}, 32'h1);
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("rspResult", {16'h0, bus.rsp_result}, {16'h0, e.result});
            checkOutput("rspCarry", {31'h0, bus.rsp_carry}, {31'h0, e.carry});
            checkOutput("rspTag", {28'h0, bus.rsp_tag}, {28'h0, e.tag});
            checkOutput("rspErr", {31'h0, bus.rsp_err}, {31'h0, e.err});
         end
         rspCycles.push_back(cycle);
      end
      if (pushNow) expQ.push_back(expectRsp(bus.req_opcode, bus.req_a, bus.req_b,
                                            bus.req_shamt, bus.req_tag));
      if (rst) expQ.delete();
      lastPush = pushNow;
      @(posedge clk);
      #1;
      cycle++;
   endtask

   task automatic tryPush(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                          input logic [4:0] sh, input logic [3:0] tag, input int maxCycles,
                          output bit accepted);
      bus.req_valid  = 1'b1;
      bus.req_opcode = op;
      bus.req_a      = a;
      bus.req_b      = b;
      bus.req_shamt  = sh;
      bus.req_tag    = tag;
      accepted       = 1'b0;
      for (int i = 0; i < maxCycles && !accepted; i++) begin
         stepCycle();
         accepted = lastPush;
      end
      bus.req_valid = 1'b0;
   endtask

   task automatic applyStimulus(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                input logic [4:0] sh, input logic [3:0] tag);
      bit accepted;
      tryPush(op, a, b, sh, tag, 200, accepted);
      if (!accepted) checkOutput("pushTimeout", {31'h0, bus.req_ready}, 32'h1);
   endtask

   task automatic drain();
      for (int i = 0; i < 200 && (expQ.size() != 0 || bus.busy); i++) stepCycle();
      checkOutput("drainBusy", {31'h0, bus.busy}, 32'h0);
      checkOutput("drainQueue", expQ.size(), 32'h0);
   endtask

   task automatic doReset();
      rst           = 1'b1;
      bus.req_valid = 1'b0;
      stepCycle();
      stepCycle();
      rst = 1'b0;
   endtask

   initial begin
      bit          accepted;
      int          accCount;
      int          seen;
      int          issued;
      int          guard;
      bit          pending;
      logic [3:0]  savedOp;
      logic [15:0] savedIn1;
      logic [15:0] savedIn2;

      rst            = 1'b1;
      bus.req_valid  = 1'b0;
      bus.req_opcode = 4'h0;
      bus.req_a      = 16'h0;
      bus.req_b      = 16'h0;
      bus.req_shamt  = 5'h0;
      bus.req_tag    = 4'h0;
      bus.rsp_ready  = 1'b0;
      @(posedge clk);
      #1;

      doReset();
      checkOutput("resetRspValid", {31'h0, bus.rsp_valid}, 32'h0);
      checkOutput("resetReqReady", {31'h0, bus.req_ready}, 32'h1);
      checkOutput("resetBusy", {31'h0, bus.busy}, 32'h0);
      checkOutput("resetAluOp", {28'h0, bus.alu_opcode}, 32'h0);
      checkOutput("resetAluIn1", {16'h0, bus.alu_input1}, 32'h0);
      checkOutput("resetAluIn2", {16'h0, bus.alu_input2}, 32'h0);
      checkOutput("resetAluShift", {27'h0, bus.alu_shift_value}, 32'h0);
      checkOutput("resetRspFields", rspFields(), 32'h0);

      $display("[TB] ADD with carry and latency");
      bus.rsp_ready = 1'b1;
      applyStimulus(OPC_ADD, 16'hFFFF, 16'h0001, 5'd0, 4'd3);
      checkOutput("addT1Valid", {31'h0, bus.rsp_valid}, 32'h0);
      checkOutput("addT1Busy", {31'h0, bus.busy}, 32'h1);
      stepCycle();
      checkOutput("addT2AluOp", {28'h0, bus.alu_opcode}, {28'h0, OPC_ADD});
      checkOutput("addT2AluIn1", {16'h0, bus.alu_input1}, 32'hFFFF);
      checkOutput("addT2AluIn2", {16'h0, bus.alu_input2}, 32'h0001);
      checkOutput("addT2Valid", {31'h0, bus.rsp_valid}, 32'h0);
      stepCycle();
      checkOutput("addT3Valid", {31'h0, bus.rsp_valid}, 32'h1);
      checkOutput("addT3Rsp", rspFields(), packRsp(1'b0, 4'd3, 1'b1, 16'h0000));
      drain();

      $display("[TB] back-to-back SUB then SLL");
      rspCycles.delete();
      applyStimulus(OPC_SUB, 16'h0005, 16'h0003, 5'd0, 4'd1);
      applyStimulus(OPC_SLL, 16'h0001, 16'h0000, 5'd4, 4'd2);
      drain();
      checkOutput("b2bCount", rspCycles.size(), 32'd2);
      if (rspCycles.size() == 2) checkOutput("b2bSpacing", rspCycles[1] - rspCycles[0], 32'd2);

      $display("[TB] backpressure with full queue");
      bus.rsp_ready = 1'b0;
      accCount = 0;
      for (int i = 0; i < 6; i++) begin
         tryPush(4'(i % 4), 16'($urandom), 16'($urandom), 5'($urandom_range(0, 31)), 4'(i), 6,
                 accepted);
         if (accepted) accCount++;
      end
      checkOutput("bpAccepted", accCount, 32'd5);
      checkOutput("bpReqReady", {31'h0, bus.req_ready}, 32'h0);
      checkOutput("bpRspValid", {31'h0, bus.rsp_valid}, 32'h1);
      checkOutput("bpRspTag", {28'h0, bus.rsp_tag}, 32'h0);
      bus.rsp_ready = 1'b1;
      drain();
      checkOutput("bpReqReadyAfter", {31'h0, bus.req_ready}, 32'h1);

      $display("[TB] illegal opcode");
      savedOp  = bus.alu_opcode;
      savedIn1 = bus.alu_input1;
      savedIn2 = bus.alu_input2;
      applyStimulus(4'hC, 16'h1234, 16'h5678, 5'd3, 4'd7);
      stepCycle();
      checkOutput("illegalValid", {31'h0, bus.rsp_valid}, 32'h1);
      checkOutput("illegalRsp", rspFields(), packRsp(1'b1, 4'd7, 1'b0, 16'h0));
      checkOutput("illegalAluOp", {28'h0, bus.alu_opcode}, {28'h0, savedOp});
      checkOutput("illegalAluIn1", {16'h0, bus.alu_input1}, {16'h0, savedIn1});
      checkOutput("illegalAluIn2", {16'h0, bus.alu_input2}, {16'h0, savedIn2});
      drain();

      $display("[TB] DIV by zero");
      savedOp  = bus.alu_opcode;
      savedIn1 = bus.alu_input1;
      applyStimulus(OPC_DIV, 16'h0007, 16'h0000, 5'd0, 4'd9);
      stepCycle();
`ifdef ALU_SEQ_DIV0_ERR_EN
      checkOutput("div0Valid", {31'h0, bus.rsp_valid}, 32'h1);
      checkOutput("div0Rsp", rspFields(), packRsp(1'b1, 4'd9, 1'b0, 16'h0));
      checkOutput("div0AluOp", {28'h0, bus.alu_opcode}, {28'h0, savedOp});
      checkOutput("div0AluIn1", {16'h0, bus.alu_input1}, {16'h0, savedIn1});
`else
      checkOutput("div0AluOp", {28'h0, bus.alu_opcode}, {28'h0, OPC_DIV});
      checkOutput("div0AluIn1", {16'h0, bus.alu_input1}, 32'h0007);
      checkOutput("div0EarlyValid", {31'h0, bus.rsp_valid}, 32'h0);
      stepCycle();
      checkOutput("div0Valid", {31'h0, bus.rsp_valid}, 32'h1);
      checkOutput("div0Rsp", rspFields(), packRsp(1'b0, 4'd9, 1'b0, 16'h0));
`endif
      drain();

      $display("[TB] reset during SETTLE");
      bus.rsp_ready = 1'b0;
      applyStimulus(OPC_ADD, 16'h1111, 16'h0001, 5'd0, 4'd10);
      applyStimulus(OPC_OR,  16'h00F0, 16'h0F00, 5'd2, 4'd11);
      applyStimulus(OPC_AND, 16'h0FF0, 16'h00FF, 5'd0, 4'd12);
      applyStimulus(OPC_SUB, 16'h0009, 16'h0004, 5'd0, 4'd13);
      for (int i = 0; i < 20 && !bus.rsp_valid; i++) stepCycle();
      checkOutput("rstPreValid", {31'h0, bus.rsp_valid}, 32'h1);
      bus.rsp_ready = 1'b1;
      stepCycle();
      bus.rsp_ready = 1'b0;
      checkOutput("rstInSettleValid", {31'h0, bus.rsp_valid}, 32'h0);
      checkOutput("rstInSettleBusy", {31'h0, bus.busy}, 32'h1);
      rst = 1'b1;
      stepCycle();
      rst = 1'b0;
      checkOutput("rstMidValid", {31'h0, bus.rsp_valid}, 32'h0);
      checkOutput("rstMidBusy", {31'h0, bus.busy}, 32'h0);
      checkOutput("rstMidReqReady", {31'h0, bus.req_ready}, 32'h1);
      checkOutput("rstMidAluOp", {28'h0, bus.alu_opcode}, 32'h0);
      checkOutput("rstMidAluIn1", {16'h0, bus.alu_input1}, 32'h0);
      checkOutput("rstMidAluIn2", {16'h0, bus.alu_input2}, 32'h0);
      checkOutput("rstMidAluShift", {27'h0, bus.alu_shift_value}, 32'h0);
      bus.rsp_ready = 1'b1;
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         if (bus.rsp_valid) seen++;
         stepCycle();
      end
      checkOutput("rstNoStaleRsp", seen, 32'd0);

      $display("[TB] random traffic");
      issued  = 0;
      guard   = 0;
      pending = 1'b0;
      while ((issued < 200 || pending || expQ.size() != 0) && guard < 20000) begin
         if (!pending && issued < 200 && $urandom_range(0, 2) != 0) begin
            pending        = 1'b1;
            bus.req_valid  = 1'b1;
            bus.req_opcode = 4'($urandom_range(0, 11));
            bus.req_a      = 16'($urandom);
            bus.req_b      = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
            bus.req_shamt  = 5'($urandom_range(0, 31));
            bus.req_tag    = 4'(issued);
         end
         bus.rsp_ready = ($urandom_range(0, 3) != 0);
         stepCycle();
         if (lastPush) begin
            pending       = 1'b0;
            bus.req_valid = 1'b0;
            issued++;
         end
         guard++;
      end
      checkOutput("randomIssued", issued, 32'd200);
      bus.rsp_ready = 1'b1;
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
